// File: rtl/cmd_proc_pkg.sv
// Shared definitions for the command dispatcher: FSM encoding, default broadcast code
// and the layout of a buffered command word.
package cmd_proc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } disp_state_e;

  localparam logic [7:0] DEFAULT_BCAST_CMD = 8'hFF;
  localparam int unsigned DEFAULT_CMD_W    = 8;
  localparam int unsigned DEFAULT_DATA_W   = 16;

  // A FIFO word is {cmd, data}; cmd occupies the upper bits.
  typedef struct packed {
    logic [DEFAULT_CMD_W-1:0]  cmd;
    logic [DEFAULT_DATA_W-1:0] data;
  } cmd_word_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered storage. Push when full and pop when empty are ignored.
// The head word is visible on rdata_o whenever empty_o is low.
module cmd_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are exactly AW bits wide, so wrap is the natural overflow.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// Buffers {cmd, data} words, decodes each to a unicast/broadcast engine mask and drives
// per-engine RTS until every targeted engine has answered with RTR. Illegal codes are dropped and counted.
module cmd_dispatcher
  import cmd_proc_pkg::*;
#(
  parameter int                NUM_ENGINES = 5,
  parameter int                CMD_W       = 8,
  parameter int                DATA_W      = 16,
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [CMD_W-1:0]  BCAST_CMD   = CMD_W'(DEFAULT_BCAST_CMD),
  parameter int                ERR_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_rtr,
  input  logic [CMD_W-1:0]       cmd,
  input  logic [DATA_W-1:0]      i2c_in_data,
  output logic [NUM_ENGINES-1:0] engine_out_rts,
  input  logic [NUM_ENGINES-1:0] engine_in_rtr,
  output logic [DATA_W-1:0]      bcast_out_data,
  output logic [CMD_W-1:0]       bcast_out_cmd,
  output logic                   busy,
  input  logic                   abort,
  output logic [ERR_W-1:0]       err_count,
  output disp_state_e            dbg_state
);

  localparam int WORD_W = CMD_W + DATA_W;

  disp_state_e            state_q;
  logic [NUM_ENGINES-1:0] pending_q;
  logic [DATA_W-1:0]      data_q;
  logic [CMD_W-1:0]       cmd_q;
  logic [ERR_W-1:0]       err_q;

  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [WORD_W-1:0]      fifo_head;
  logic [CMD_W-1:0]       head_cmd;
  logic [DATA_W-1:0]      head_data;
  logic [NUM_ENGINES-1:0] head_mask;
  logic                   head_legal;
  logic [NUM_ENGINES-1:0] pending_d;
  logic                   all_done;

  assign fifo_push = cmd_valid && cmd_rtr;
  assign head_cmd  = fifo_head[WORD_W-1:DATA_W];
  assign head_data = fifo_head[DATA_W-1:0];

  cmd_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i ({cmd, i2c_in_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Unicast is tested first so a small engine index never aliases the broadcast code.
  always_comb begin
    head_mask  = '0;
    head_legal = 1'b0;
    if (32'(head_cmd) < NUM_ENGINES) begin
      head_mask  = NUM_ENGINES'(1) << head_cmd;
      head_legal = 1'b1;
    end else if (head_cmd == BCAST_CMD) begin
      head_mask  = '1;
      head_legal = 1'b1;
    end
  end

  // RTR only counts for engines still pending, so stray RTR on idle lanes is ignored.
  assign pending_d = pending_q & ~engine_in_rtr;
  assign all_done  = (pending_d == '0);

  always_comb begin
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE:  fifo_pop = !fifo_empty;
      ST_ISSUE: fifo_pop = !abort && all_done && !fifo_empty;
      default:  fifo_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      data_q    <= '0;
      cmd_q     <= '0;
      err_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty && head_legal) begin
            pending_q <= head_mask;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (abort) begin
            pending_q <= '0;
            state_q   <= ST_IDLE;
          end else if (all_done) begin
            if (!fifo_empty && head_legal) begin
              pending_q <= head_mask;
            end else begin
              pending_q <= '0;
              state_q   <= ST_IDLE;
            end
          end else begin
            pending_q <= pending_d;
          end
        end
        default: begin
          pending_q <= '0;
          state_q   <= ST_IDLE;
        end
      endcase

      if (fifo_pop) begin
        data_q <= head_data;
        cmd_q  <= head_cmd;
        if (!head_legal && (err_q != '1)) err_q <= err_q + 1'b1;
      end
    end
  end

  assign cmd_rtr        = !fifo_full && !rst;
  assign busy           = (state_q == ST_ISSUE) || !fifo_empty;
  assign engine_out_rts = pending_q;
  assign bcast_out_data = data_q;
  assign bcast_out_cmd  = cmd_q;
  assign err_count      = err_q;
  assign dbg_state      = state_q;

endmodule
